// File: rtl/tt_core_io_bridge_pkg.sv
// Shared types and defaults for the core I/O bridge: FSM state encoding,
// default word/port widths and a beat-counter width helper.
package tt_core_io_bridge_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PORT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_LOAD_INSTR = 3'd0,
    ST_LOAD_DATA  = 3'd1,
    ST_STEP       = 3'd2,
    ST_SEND_RES   = 3'd3,
    ST_SEND_ADDR  = 3'd4
  } state_e;

  // Beat counter width: clog2 of the beat count, never narrower than one bit.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/tt_beat_shifter.sv
// Word register with a beat counter. Beats can be written one at a time at
// the counter position (serial-to-parallel), or a whole word can be loaded
// and read back one beat at a time (parallel-to-serial). The counter wraps
// to zero after the last beat, so it is zero again whenever a word completes.
module tt_beat_shifter
  import tt_core_io_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PORT_WIDTH = DEFAULT_PORT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_wr,
  input  logic [PORT_WIDTH-1:0] i_beat,
  input  logic                  i_adv,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [PORT_WIDTH-1:0] o_beat,
  output logic                  o_last
);

  localparam int BEATS = DATA_WIDTH / PORT_WIDTH;
  localparam int CW    = beat_cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  logic [DATA_WIDTH-1:0] r_word;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_inc;
  logic [PORT_WIDTH-1:0] w_beat;

  // Next counter value, wrapping to zero after the final beat.
  always_comb begin
    if (r_cnt == LAST_BEAT) begin
      w_cnt_inc = '0;
    end else begin
      w_cnt_inc = r_cnt + CNT_ONE;
    end
  end

  // AND-OR select of the beat addressed by the counter.
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < BEATS; i++) begin
      w_beat = w_beat | ({PORT_WIDTH{r_cnt == CW'(i)}} & r_word[i*PORT_WIDTH +: PORT_WIDTH]);
    end
  end

  // Word/counter update: reset, then parallel load, then beat write or advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= '0;
    end else if (i_wr) begin
      for (int i = 0; i < BEATS; i++) begin
        if (r_cnt == CW'(i)) begin
          r_word[i*PORT_WIDTH +: PORT_WIDTH] <= i_beat;
        end
      end
      r_cnt <= w_cnt_inc;
    end else if (i_adv) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign o_word = r_word;
  assign o_beat = w_beat;
  assign o_last = (r_cnt == LAST_BEAT);

endmodule

// File: rtl/tt_core_io_bridge.sv
// Byte-port bridge between a host and a single-step core datapath.
// Loads an instruction word and a read-data word beat by beat, strobes the
// datapath for one cycle, then streams back the ALU result and (optionally)
// the memory address with the write-enable folded into its top bit.
module tt_core_io_bridge
  import tt_core_io_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PORT_WIDTH = DEFAULT_PORT_WIDTH,
  parameter int SEND_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [PORT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] core_instr,
  output logic [DATA_WIDTH-1:0] core_read_data,
  output logic                  core_step,
  input  logic [DATA_WIDTH-1:0] core_alu_result,
  input  logic [DATA_WIDTH-1:0] core_addr,
  input  logic                  core_write_enable,
  output logic                  busy
);

  state_e r_state;
  state_e w_state_nxt;

  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_core_step;
  logic [DATA_WIDTH-1:0] r_cap_addr;
  logic                  r_cap_we;

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_instr_wr;
  logic                  w_data_wr;
  logic                  w_instr_last;
  logic                  w_data_last;
  logic                  w_out_last;
  logic                  w_out_load;
  logic [DATA_WIDTH-1:0] w_out_word_in;
  logic [DATA_WIDTH-1:0] w_addr_word;
  logic [DATA_WIDTH-1:0] w_instr_word;
  logic [DATA_WIDTH-1:0] w_data_word;
  logic [DATA_WIDTH-1:0] w_out_word;
  logic [PORT_WIDTH-1:0] w_instr_beat;
  logic [PORT_WIDTH-1:0] w_data_beat;
  logic [PORT_WIDTH-1:0] w_out_beat;

  // Handshakes use the registered ready/valid, which track the state exactly.
  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Address beat stream: the final beat's top bit carries the write enable.
  assign w_addr_word = {r_cap_we, r_cap_addr[DATA_WIDTH-2:0]};

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD_INSTR: begin
        if (w_in_xfer && w_instr_last) begin
          w_state_nxt = ST_LOAD_DATA;
        end else begin
          w_state_nxt = ST_LOAD_INSTR;
        end
      end
      ST_LOAD_DATA: begin
        if (w_in_xfer && w_data_last) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_LOAD_DATA;
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        if (w_out_xfer && w_out_last) begin
          if (SEND_ADDR != 0) begin
            w_state_nxt = ST_SEND_ADDR;
          end else begin
            w_state_nxt = ST_LOAD_INSTR;
          end
        end else begin
          w_state_nxt = ST_SEND_RES;
        end
      end
      ST_SEND_ADDR: begin
        if (w_out_xfer && w_out_last) begin
          w_state_nxt = ST_LOAD_INSTR;
        end else begin
          w_state_nxt = ST_SEND_ADDR;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD_INSTR;
      end
    endcase
  end

  // Shifter controls: beat writes in the load states; output shifter takes the
  // result at STEP and the address word as the last result beat leaves.
  always_comb begin
    w_instr_wr    = 1'b0;
    w_data_wr     = 1'b0;
    w_out_load    = 1'b0;
    w_out_word_in = core_alu_result;
    if (r_state == ST_LOAD_INSTR) begin
      w_instr_wr = w_in_xfer;
    end else if (r_state == ST_LOAD_DATA) begin
      w_data_wr = w_in_xfer;
    end else if (r_state == ST_STEP) begin
      w_out_load    = 1'b1;
      w_out_word_in = core_alu_result;
    end else if ((r_state == ST_SEND_RES) && (SEND_ADDR != 0)) begin
      w_out_load    = w_out_xfer && w_out_last;
      w_out_word_in = w_addr_word;
    end else begin
      w_out_load    = 1'b0;
      w_out_word_in = core_alu_result;
    end
  end

  // State register, registered handshake/status outputs and STEP capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD_INSTR;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_core_step <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_LOAD_INSTR) || (w_state_nxt == ST_LOAD_DATA);
      r_out_valid <= (w_state_nxt == ST_SEND_RES) || (w_state_nxt == ST_SEND_ADDR);
      r_busy      <= (w_state_nxt != ST_LOAD_INSTR);
      r_core_step <= (w_state_nxt == ST_STEP);
      if (r_state == ST_STEP) begin
        r_cap_addr <= core_addr;
        r_cap_we   <= core_write_enable;
      end
    end
  end

  tt_beat_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_instr_shifter (
    .clk    (clk),
    .rst    (rst),
    .i_load (1'b0),
    .i_word ({DATA_WIDTH{1'b0}}),
    .i_wr   (w_instr_wr),
    .i_beat (in_data),
    .i_adv  (1'b0),
    .o_word (w_instr_word),
    .o_beat (w_instr_beat),
    .o_last (w_instr_last)
  );

  tt_beat_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_data_shifter (
    .clk    (clk),
    .rst    (rst),
    .i_load (1'b0),
    .i_word ({DATA_WIDTH{1'b0}}),
    .i_wr   (w_data_wr),
    .i_beat (in_data),
    .i_adv  (1'b0),
    .o_word (w_data_word),
    .o_beat (w_data_beat),
    .o_last (w_data_last)
  );

  // The output shifter's word register holds the captured result, then the
  // captured address word.
  tt_beat_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_out_shifter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_out_load),
    .i_word (w_out_word_in),
    .i_wr   (1'b0),
    .i_beat ({PORT_WIDTH{1'b0}}),
    .i_adv  (w_out_xfer),
    .o_word (w_out_word),
    .o_beat (w_out_beat),
    .o_last (w_out_last)
  );

  // Shifter ports and address bit that this configuration never reads.
  logic w_unused_ok;
  assign w_unused_ok = ^{w_instr_beat, w_data_beat, w_out_word, r_cap_addr[DATA_WIDTH-1]};

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = w_out_beat;
  assign busy           = r_busy;
  assign core_step      = r_core_step;
  assign core_instr     = w_instr_word;
  assign core_read_data = w_data_word;

endmodule

// File: tb/tb_tt_core_io_bridge.sv
// Self-checking bench for tt_core_io_bridge: a 32/8 instance with address
// return and a 16/4 instance without it, checked against per-transaction
// expectations built from the words being exchanged.
module tb_tt_core_io_bridge;

  logic clk = 1'b0;
  logic rst;

  // 32-bit word, 8-bit port, address returned
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [31:0] core_instr, core_read_data, core_alu_result, core_addr;
  logic        core_step, core_write_enable, busy;

  // 16-bit word, 4-bit port, result only
  logic [3:0]  n_in_data;
  logic        n_in_valid, n_in_ready;
  logic [3:0]  n_out_data;
  logic        n_out_valid, n_out_ready;
  logic [15:0] n_core_instr, n_core_read_data, n_core_alu_result, n_core_addr;
  logic        n_core_step, n_core_write_enable, n_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tt_core_io_bridge #(.DATA_WIDTH(32), .PORT_WIDTH(8), .SEND_ADDR(1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .core_instr(core_instr), .core_read_data(core_read_data), .core_step(core_step),
    .core_alu_result(core_alu_result), .core_addr(core_addr),
    .core_write_enable(core_write_enable), .busy(busy)
  );

  tt_core_io_bridge #(.DATA_WIDTH(16), .PORT_WIDTH(4), .SEND_ADDR(0)) dut_n (
    .clk(clk), .rst(rst),
    .in_data(n_in_data), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .out_data(n_out_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .core_instr(n_core_instr), .core_read_data(n_core_read_data), .core_step(n_core_step),
    .core_alu_result(n_core_alu_result), .core_addr(n_core_addr),
    .core_write_enable(n_core_write_enable), .busy(n_busy)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    n_in_valid = 1'b1; n_in_data = 4'hF; n_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    n_vec++;
    if ({in_ready, busy, out_valid, core_step} !== 4'b1000 || core_instr !== 32'd0 || core_read_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_wide: rdy/busy/ov/step=%b instr=%h data=%h, want 1000 0 0",
               {in_ready, busy, out_valid, core_step}, core_instr, core_read_data);
    end
    n_vec++;
    if ({n_in_ready, n_busy, n_out_valid, n_core_step} !== 4'b1000 || n_core_instr !== 16'd0 || n_core_read_data !== 16'd0) begin
      n_err++;
      $display("FAIL reset_narrow: rdy/busy/ov/step=%b instr=%h data=%h, want 1000 0 0",
               {n_in_ready, n_busy, n_out_valid, n_core_step}, n_core_instr, n_core_read_data);
    end
  endtask

  // One full transaction on the wide instance. in_mode/out_mode: 0 always
  // valid/ready, 1 random, 2 directed gap (3 idle cycles before beat 2) /
  // stall (5 cycles on result beat 2). abort_* >= 0 resets at that beat.
  task automatic run_txn(input logic [31:0] instr, input logic [31:0] rdata,
                         input logic [31:0] res, input logic [31:0] addr, input logic we,
                         input int in_mode, input int out_mode,
                         input int abort_load, input int abort_send);
    logic [63:0] ld;
    logic [63:0] snd;
    logic [3:0]  st_got, st_exp;
    int acc, gap, k, hold;
    logic v, r;
    ld  = {rdata, instr};
    snd = {we, addr[30:0], res};
    core_alu_result = res; core_addr = addr; core_write_enable = we;
    acc = 0; gap = 0;
    while (acc < 8) begin
      st_got = {in_ready, busy, out_valid, core_step};
      st_exp = {1'b1, (acc >= 4), 2'b00};
      n_vec++;
      if (st_got !== st_exp) begin
        n_err++;
        $display("FAIL load_status beat %0d: got %b want %b", acc, st_got, st_exp);
      end
      if (acc == abort_load) begin
        rst = 1'b1; in_valid = 1'b1; in_data = ld[8*acc +: 8];
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (core_instr !== 32'd0 || core_read_data !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL abort_load: instr=%h data=%h rdy=%b busy=%b, want 0 0 1 0",
                   core_instr, core_read_data, in_ready, busy);
        end
        return;
      end
      case (in_mode)
        1: v = 1'($urandom_range(0, 1));
        2: begin
          if (acc == 2 && gap < 3) begin
            v = 1'b0;
            gap++;
          end else begin
            v = 1'b1;
          end
        end
        default: v = 1'b1;
      endcase
      in_valid = v;
      in_data  = v ? ld[8*acc +: 8] : 8'($urandom);
      @(negedge clk);
      if (v) acc++;
    end

    // STEP cycle: a valid beat offered here must be ignored
    in_valid = 1'b1; in_data = 8'($urandom);
    st_got = {in_ready, busy, out_valid, core_step};
    n_vec++;
    if (st_got !== 4'b0101) begin
      n_err++;
      $display("FAIL step_status: got %b want 0101", st_got);
    end
    n_vec++;
    if (core_instr !== instr || core_read_data !== rdata) begin
      n_err++;
      $display("FAIL assembled: instr=%h data=%h, want %h %h", core_instr, core_read_data, instr, rdata);
    end
    @(negedge clk);
    core_alu_result = $urandom; core_addr = $urandom; core_write_enable = 1'($urandom_range(0, 1));

    k = 0; hold = 0;
    while (k < 8) begin
      st_got = {in_ready, busy, out_valid, core_step};
      n_vec++;
      if (st_got !== 4'b0110 || out_data !== snd[8*k +: 8]) begin
        n_err++;
        $display("FAIL send_beat %0d: status=%b data=%h, want 0110 %h", k, st_got, out_data, snd[8*k +: 8]);
      end
      if (k == abort_send) begin
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || core_instr !== 32'd0) begin
          n_err++;
          $display("FAIL abort_send: ov=%b rdy=%b busy=%b instr=%h, want 0 1 0 0",
                   out_valid, in_ready, busy, core_instr);
        end
        in_valid = 1'b0;
        return;
      end
      case (out_mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          if (k == 2 && hold < 5) begin
            r = 1'b0;
            hold++;
          end else begin
            r = 1'b1;
          end
        end
        default: r = 1'b1;
      endcase
      out_ready = r;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      @(negedge clk);
      if (r) k++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    st_got = {in_ready, busy, out_valid, core_step};
    n_vec++;
    if (st_got !== 4'b1000) begin
      n_err++;
      $display("FAIL idle_after: got %b want 1000", st_got);
    end
    n_vec++;
    if (core_instr !== instr || core_read_data !== rdata) begin
      n_err++;
      $display("FAIL words_held: instr=%h data=%h, want %h %h", core_instr, core_read_data, instr, rdata);
    end
  endtask

  task automatic test_basic();
    run_txn(32'h0000_0513, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_out_stall();
    run_txn(32'h0000_0513, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 0, 2, -1, -1);
  endtask

  task automatic test_in_gap();
    run_txn(32'hA5C3_1E0F, 32'h0BAD_F00D, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 2, 0, -1, -1);
  endtask

  task automatic test_reset_mid_load();
    run_txn($urandom, $urandom, $urandom, $urandom, 1'b1, 0, 0, 2, -1);
    run_txn($urandom, $urandom, $urandom, $urandom, 1'b0, 0, 0, 6, -1);
    run_txn(32'h0000_0513, 32'hCAFE_0001, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_reset_mid_send();
    run_txn($urandom, $urandom, $urandom, $urandom, 1'b1, 0, 1, -1, 5);
    run_txn($urandom, $urandom, $urandom, $urandom, 1'b1, 1, 1, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      run_txn($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1, 1, -1, -1);
    end
  endtask

  task automatic test_narrow(input logic [15:0] instr, input logic [15:0] rdata,
                             input logic [15:0] res, input logic [15:0] addr);
    logic [31:0] ld;
    ld = {rdata, instr};
    n_core_alu_result = res; n_core_addr = addr; n_core_write_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (n_in_ready !== 1'b1 || n_core_step !== 1'b0 || n_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL narrow_load beat %0d: rdy=%b step=%b ov=%b, want 1 0 0", i, n_in_ready, n_core_step, n_out_valid);
      end
      n_in_valid = 1'b1; n_in_data = ld[4*i +: 4];
      @(negedge clk);
    end
    n_in_valid = 1'b0;
    n_vec++;
    if (n_core_step !== 1'b1 || n_core_instr !== instr || n_core_read_data !== rdata) begin
      n_err++;
      $display("FAIL narrow_step: step=%b instr=%h data=%h, want 1 %h %h", n_core_step, n_core_instr, n_core_read_data, instr, rdata);
    end
    n_out_ready = 1'b1;
    @(negedge clk);
    n_core_alu_result = 16'($urandom); n_core_addr = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (n_out_valid !== 1'b1 || n_out_data !== res[4*i +: 4]) begin
        n_err++;
        $display("FAIL narrow_send beat %0d: ov=%b data=%h, want 1 %h", i, n_out_valid, n_out_data, res[4*i +: 4]);
      end
      @(negedge clk);
    end
    n_out_ready = 1'b0;
    n_vec++;
    if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1 || n_busy !== 1'b0) begin
      n_err++;
      $display("FAIL narrow_no_addr: ov=%b rdy=%b busy=%b, want 0 1 0", n_out_valid, n_in_ready, n_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    core_alu_result = 32'd0; core_addr = 32'd0; core_write_enable = 1'b0;
    n_in_data = 4'h0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    n_core_alu_result = 16'd0; n_core_addr = 16'd0; n_core_write_enable = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_out_stall();
    test_in_gap();
    test_reset_mid_load();
    test_reset_mid_send();
    test_back_to_back();
    test_narrow(16'h0513, 16'hBEEF, 16'hA5C3, 16'h1234);
    test_narrow(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_core_io_bridge.md
TT_CORE_IO_BRIDGE -- requirements
Module: tt_core_io_bridge

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the core instruction, read-data, result and address words.
REQ-002 Parameter: PORT_WIDTH, default 8, host byte-port width; DATA_WIDTH SHALL be an integer multiple of PORT_WIDTH (BEATS = DATA_WIDTH/PORT_WIDTH).
REQ-003 Parameter: SEND_ADDR, default 1, 1 = return the address word after the result word; 0 = result word only.
REQ-004 clk  in  1  the block's only clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_data  in  PORT_WIDTH  host input beat.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  bridge accepts a beat this cycle.
REQ-009 out_data  out  PORT_WIDTH  host output beat.
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_ready  in  1  host accepts out_data.
REQ-012 core_instr  out  DATA_WIDTH  assembled instruction to the datapath.
REQ-013 core_read_data  out  DATA_WIDTH  assembled memory read data to the datapath.
REQ-014 core_step  out  1  one-cycle execute strobe to the datapath.
REQ-015 core_alu_result  in  DATA_WIDTH  datapath ALU result.
REQ-016 core_addr  in  DATA_WIDTH  datapath memory address.
REQ-017 core_write_enable  in  1  datapath memory write enable.
REQ-018 busy  out  1  high in every state except LOAD_INSTR.

Function
REQ-019 FSM states, in order: LOAD_INSTR, LOAD_DATA, STEP, SEND_RES, SEND_ADDR.
REQ-020 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-021 in_ready SHALL be 1 exactly in LOAD_INSTR and LOAD_DATA.
REQ-022 LOAD_INSTR: each transfer writes in_data into core_instr slice [beat*PORT_WIDTH +: PORT_WIDTH], LSB beat first; after BEATS transfers go to LOAD_DATA with the beat counter at 0.
REQ-023 LOAD_DATA: same assembly into core_read_data; after BEATS transfers go to STEP.
REQ-024 STEP: lasts exactly one cycle with core_step=1. At that edge core_alu_result, core_addr and core_write_enable SHALL be captured into internal registers. The FSM then goes to SEND_RES.
REQ-025 SEND_RES: out_valid=1; out_data = captured result slice for the current beat, LSB first. After BEATS transfers, go to SEND_ADDR if SEND_ADDR=1, else LOAD_INSTR.
REQ-026 SEND_ADDR: as SEND_RES with the captured address. On the final beat, out_data MSB SHALL be replaced by the captured write_enable. After BEATS transfers, return to LOAD_INSTR.
REQ-027 While out_valid=1 and out_ready=0, out_data SHALL hold stable and the beat counter SHALL not advance.
REQ-028 in_valid=0 SHALL stall loading indefinitely without altering assembled bits.
REQ-029 in_valid asserted outside load states SHALL be ignored; no data is lost or accepted.
REQ-030 core_instr and core_read_data SHALL hold their values from assembly until overwritten by the next load.
REQ-031 The beat counter is clog2(BEATS) bits wide (minimum 1), wraps to 0 at every state change, and never exceeds BEATS-1.
REQ-032 Minimum round-trip latency for DATA_WIDTH=32, PORT_WIDTH=8, SEND_ADDR=1 with host always ready: 8 load cycles + 1 STEP + 8 send cycles = 17 cycles.

Reset
REQ-033 rst=1 at a clock edge SHALL force: state LOAD_INSTR, beat counter 0, core_instr 0, core_read_data 0, captured registers 0, core_step 0, out_valid 0, in_ready 1, busy 0.
REQ-034 Reset asserted mid-load or mid-send SHALL abandon the transaction; the next transfer after reset is beat 0 of a new instruction.
REQ-035 rst has priority over every transfer in the same cycle.

Structure
REQ-036 A shared package SHALL hold the FSM state enum and the default DATA_WIDTH/PORT_WIDTH constants.
REQ-037 One sub-module is natural: tt_beat_shifter, a parametrised serial-to-parallel/parallel-to-serial word register with a beat counter. It is instantiated for input assembly and for output serialisation.
REQ-038 The datapath is instantiated at the tile top, not inside this block.

Verification
REQ-039 Reset, then load beats 13,05,00,00 and 00,00,00,00 with in_valid held high -> core_instr=0x00000513; core_step pulses exactly once, 8 cycles after the first accepted beat.
REQ-040 Drive core_alu_result=0xDEADBEEF and core_addr=0x00000010 with core_write_enable=1 at STEP -> out beats EF,BE,AD,DE,10,00,00,80.
REQ-041 Hold out_ready=0 for 5 cycles during SEND_RES beat 2 -> out_data stays AD and out_valid stays 1; the sequence completes unchanged afterwards.
REQ-042 Gap in_valid low for 3 cycles between instruction beats 1 and 2 -> no extra beat accepted; assembled word correct.
REQ-043 Assert rst after 2 instruction beats -> core_instr=0, in_ready=1; a new 8-beat load then produces a correct step.
REQ-044 Parametrise DATA_WIDTH=16, PORT_WIDTH=4, SEND_ADDR=0 -> 4 load beats per word, 4 result beats, and return to LOAD_INSTR with no address beats.
